// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one byte-enable BRAM port among NUM_REQ requesters.
// Optional BRAM_ARB_CLEAR_EN compiles in a post-reset zero-fill of the whole RAM.
module bram_port_arbiter #(
  parameter  int LINES   = 4096,
  parameter  int NUM_REQ = 2,
  localparam int AW      = $clog2(LINES),
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*AW-1:0] req_addr_i,
  input  logic [NUM_REQ*4-1:0]  req_be_i,
  input  logic [NUM_REQ*32-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic                  rsp_valid_o,
  output logic [IW-1:0]         rsp_id_o,
  output logic [31:0]           rsp_data_o,
  output logic                  init_done_o,
  output logic                  ram_en_o,
  output logic [AW-1:0]         ram_addr_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_data_in_o,
  input  logic [31:0]           ram_data_out_i
);

  // state | meaning
  // IDLE  | held in reset / first cycle after release, port idle
  // CLEAR | zero-filling the RAM one word per cycle (clear build only)
  // RUN   | round-robin arbitration of requesters
`ifdef BRAM_ARB_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CLEAR = 2'd1, ST_RUN = 2'd2} state_e;
`else
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
`endif

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [IW-1:0] rsp_id_q, rsp_id_d;
  logic          found;
  logic [IW-1:0] gnt_idx;

  logic [AW-1:0] addr_a  [NUM_REQ];
  logic [3:0]    be_a    [NUM_REQ];
  logic [31:0]   wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr_i[g*AW +: AW];
    assign be_a[g]    = req_be_i[g*4 +: 4];
    assign wdata_a[g] = req_wdata_i[g*32 +: 32];
  end

`ifdef BRAM_ARB_CLEAR_EN
  logic [AW-1:0] cnt_q, cnt_d;
`endif

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      automatic int k = int'(ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req_valid_i[IW'(k)]) begin
        found   = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    req_ready_o   = '0;
    ram_en_o      = 1'b0;
    ram_addr_o    = '0;
    ram_be_o      = '0;
    ram_data_in_o = '0;
`ifdef BRAM_ARB_CLEAR_EN
    cnt_d         = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef BRAM_ARB_CLEAR_EN
        state_d = ST_CLEAR;
`else
        state_d = ST_RUN;
`endif
      end
`ifdef BRAM_ARB_CLEAR_EN
      ST_CLEAR: begin
        ram_en_o   = 1'b1;
        ram_be_o   = 4'hF;
        ram_addr_o = cnt_q;
        if (cnt_q == AW'(LINES - 1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_RUN: begin
        if (found) begin
          req_ready_o[gnt_idx] = 1'b1;
          ram_en_o             = 1'b1;
          ram_addr_o           = addr_a[gnt_idx];
          ram_be_o             = be_a[gnt_idx];
          ram_data_in_o        = wdata_a[gnt_idx];
          rsp_valid_d          = 1'b1;
          rsp_id_d             = gnt_idx;
          ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

`ifdef BRAM_ARB_CLEAR_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

  assign init_done_o = (state_q == ST_RUN);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  // RAM output is already registered; passing it through keeps the 1-cycle response.
  assign rsp_data_o  = ram_data_out_i;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: a 2-requester and a 3-requester instance, each on a
// behavioural BRAM; adapts to whether BRAM_ARB_CLEAR_EN is defined.
module tb_bram_port_arbiter;

  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: NUM_REQ=2
  logic [1:0]  a_valid, a_ready;
  logic [7:0]  a_addr, a_be;
  logic [63:0] a_wdata;
  logic        a_rsp_valid, a_init, a_en;
  logic [0:0]  a_rsp_id;
  logic [31:0] a_rsp_data, a_rdin, a_dout;
  logic [3:0]  a_raddr, a_rbe;

  // instance B: NUM_REQ=3
  logic [2:0]  b_valid, b_ready;
  logic [11:0] b_addr, b_be;
  logic [95:0] b_wdata;
  logic        b_rsp_valid, b_init, b_en;
  logic [1:0]  b_rsp_id;
  logic [31:0] b_rsp_data, b_rdin, b_dout;
  logic [3:0]  b_raddr, b_rbe;

  bram_port_arbiter #(.LINES(16), .NUM_REQ(2)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(a_valid), .req_addr_i(a_addr),
    .req_be_i(a_be), .req_wdata_i(a_wdata), .req_ready_o(a_ready),
    .rsp_valid_o(a_rsp_valid), .rsp_id_o(a_rsp_id), .rsp_data_o(a_rsp_data),
    .init_done_o(a_init), .ram_en_o(a_en), .ram_addr_o(a_raddr), .ram_be_o(a_rbe),
    .ram_data_in_o(a_rdin), .ram_data_out_i(a_dout));

  bram_port_arbiter #(.LINES(16), .NUM_REQ(3)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(b_valid), .req_addr_i(b_addr),
    .req_be_i(b_be), .req_wdata_i(b_wdata), .req_ready_o(b_ready),
    .rsp_valid_o(b_rsp_valid), .rsp_id_o(b_rsp_id), .rsp_data_o(b_rsp_data),
    .init_done_o(b_init), .ram_en_o(b_en), .ram_addr_o(b_raddr), .ram_be_o(b_rbe),
    .ram_data_in_o(b_rdin), .ram_data_out_i(b_dout));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = nw[8*b +: 8];
  endfunction

  // behavioural BRAMs: registered read, write-first per byte
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  always @(posedge clk) if (a_en) begin
    for (int b = 0; b < 4; b++) if (a_rbe[b]) mem_a[a_raddr][8*b +: 8] <= a_rdin[8*b +: 8];
    a_dout <= merge(mem_a[a_raddr], a_rdin, a_rbe);
  end
  always @(posedge clk) if (b_en) begin
    for (int b = 0; b < 4; b++) if (b_rbe[b]) mem_b[b_raddr][8*b +: 8] <= b_rdin[8*b +: 8];
    b_dout <= merge(mem_b[b_raddr], b_rdin, b_rbe);
  end

  int n_cmp = 0;
  int n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboards: expected response pushed at accept, popped one cycle later
  typedef struct packed { logic [1:0] id; logic [31:0] data; } rsp_t;
  rsp_t q_a[$], q_b[$];
  rsp_t ea, eb;
  logic [3:0] ad, bd;
  logic [31:0] ref_a [16];
  logic [31:0] ref_b [16];

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q_a.delete();
`ifdef BRAM_ARB_CLEAR_EN
      for (int i = 0; i < 16; i++) ref_a[i] = '0;
`endif
    end else begin
      if (q_a.size() != 0) begin
        ea = q_a.pop_front();
        chk("a_rsp_valid", 32'(a_rsp_valid), 32'd1);
        chk("a_rsp_id", 32'(a_rsp_id), 32'(ea.id));
        chk("a_rsp_data", a_rsp_data, ea.data);
      end else chk("a_rsp_idle", 32'(a_rsp_valid), 32'd0);
      for (int r = 0; r < 2; r++) if (a_valid[r] && a_ready[r]) begin
        ad      = a_addr[4*r +: 4];
        ea.id   = 2'(r);
        ea.data = merge(ref_a[ad], a_wdata[32*r +: 32], a_be[4*r +: 4]);
        ref_a[ad] = ea.data;
        q_a.push_back(ea);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q_b.delete();
`ifdef BRAM_ARB_CLEAR_EN
      for (int i = 0; i < 16; i++) ref_b[i] = '0;
`endif
    end else begin
      if (q_b.size() != 0) begin
        eb = q_b.pop_front();
        chk("b_rsp_valid", 32'(b_rsp_valid), 32'd1);
        chk("b_rsp_id", 32'(b_rsp_id), 32'(eb.id));
        chk("b_rsp_data", b_rsp_data, eb.data);
      end else chk("b_rsp_idle", 32'(b_rsp_valid), 32'd0);
      for (int r = 0; r < 3; r++) if (b_valid[r] && b_ready[r]) begin
        bd      = b_addr[4*r +: 4];
        eb.id   = 2'(r);
        eb.data = merge(ref_b[bd], b_wdata[32*r +: 32], b_be[4*r +: 4]);
        ref_b[bd] = eb.data;
        q_b.push_back(eb);
      end
    end
  end

  task automatic a_do(input int r, input logic [3:0] ad_i, input logic [3:0] be_i,
                      input logic [31:0] d_i);
    bit got = 1'b0;
    a_addr[4*r +: 4]   = ad_i;
    a_be[4*r +: 4]     = be_i;
    a_wdata[32*r +: 32] = d_i;
    a_valid[r]         = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      got = a_ready[r];
    end
    chk("a_grant_wait", 32'(got), 32'd1);
    @(posedge clk); #1;
    a_valid[r] = 1'b0;
  endtask

  typedef struct { bit dut; logic [2:0] valid; logic [2:0] ready; } vec_t;
  vec_t vecs[19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 3'b010, 3'b010};
    vecs[1]  = '{1'b0, 3'b011, 3'b001};
    vecs[2]  = '{1'b0, 3'b011, 3'b010};
    vecs[3]  = '{1'b0, 3'b011, 3'b001};
    vecs[4]  = '{1'b0, 3'b011, 3'b010};
    vecs[5]  = '{1'b0, 3'b011, 3'b001};
    vecs[6]  = '{1'b0, 3'b011, 3'b010};
    vecs[7]  = '{1'b0, 3'b001, 3'b001};
    vecs[8]  = '{1'b0, 3'b000, 3'b000};
    vecs[9]  = '{1'b0, 3'b010, 3'b010};
    vecs[10] = '{1'b0, 3'b001, 3'b001};
    vecs[11] = '{1'b0, 3'b000, 3'b000};
    vecs[12] = '{1'b1, 3'b100, 3'b100};
    vecs[13] = '{1'b1, 3'b111, 3'b001};
    vecs[14] = '{1'b1, 3'b111, 3'b010};
    vecs[15] = '{1'b1, 3'b111, 3'b100};
    vecs[16] = '{1'b1, 3'b011, 3'b001};
    vecs[17] = '{1'b1, 3'b010, 3'b010};
    vecs[18] = '{1'b1, 3'b000, 3'b000};

    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 32'hDEAD_0000 | 32'(i);
      mem_b[i] = 32'hBEEF_0000 | 32'(i);
`ifdef BRAM_ARB_CLEAR_EN
      ref_a[i] = '0;
      ref_b[i] = '0;
`else
      ref_a[i] = mem_a[i];
      ref_b[i] = mem_b[i];
`endif
    end

    rst_n = 1'b0;
    a_valid = '0; a_addr = '0; a_be = '0; a_wdata = '0;
    b_valid = '0; b_addr = {4'd15, 4'd7, 4'd0}; b_be = '0; b_wdata = '0;
    #2;
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_a_rsp_id", 32'(a_rsp_id), 32'd0);
    chk("rst_a_init", 32'(a_init), 32'd0);
    chk("rst_a_ram_en", 32'(a_en), 32'd0);
    chk("rst_b_init", 32'(b_init), 32'd0);
    #10 rst_n = 1'b1;
    #1 chk("pre_edge_init", 32'(a_init), 32'd0);

`ifdef BRAM_ARB_CLEAR_EN
    b_valid = 3'b111;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("clr_en", 32'(a_en), 32'd1);
      chk("clr_addr", 32'(a_raddr), 32'(i));
      chk("clr_be", 32'(a_rbe), 32'hF);
      chk("clr_data", a_rdin, 32'd0);
      chk("clr_init", 32'(a_init), 32'd0);
      chk("clr_b_ready", 32'(b_ready), 32'd0);
      if (i == 15) #1 b_valid = '0;
    end
    @(negedge clk);
    chk("clr_done_init", 32'(a_init), 32'd1);
    chk("clr_done_en", 32'(a_en), 32'd0);
`else
    @(negedge clk);
    chk("noclr_init_a", 32'(a_init), 32'd1);
    chk("noclr_init_b", 32'(b_init), 32'd1);
    chk("noclr_en", 32'(a_en), 32'd0);
`endif
    @(posedge clk); #1;

    a_do(0, 4'd5, 4'hF, 32'hA1B2C3D4);
    chk("wr_rsp_data", a_rsp_data, 32'hA1B2C3D4);
    a_do(0, 4'd5, 4'h0, 32'h0);
    chk("rd_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("rd_rsp_id", 32'(a_rsp_id), 32'd0);
    chk("rd_rsp_data", a_rsp_data, 32'hA1B2C3D4);
    a_do(0, 4'd5, 4'b0010, 32'h0000EE00);
    chk("merge_rsp_data", a_rsp_data, 32'hA1B2EED4);

    a_addr = {4'd9, 4'd5}; a_be = {4'hF, 4'h0}; a_wdata = {32'h11223344, 32'h0};
    foreach (vecs[v]) begin
      if (!vecs[v].dut) begin a_valid = vecs[v].valid[1:0]; b_valid = '0; end
      else begin a_valid = '0; b_valid = vecs[v].valid; end
      @(negedge clk);
      if (!vecs[v].dut) begin
        chk($sformatf("vec%0d_a_ready", v), 32'(a_ready), 32'(vecs[v].ready[1:0]));
        chk($sformatf("vec%0d_a_en", v), 32'(a_en), 32'(|vecs[v].ready));
        if (vecs[v].ready[0]) chk($sformatf("vec%0d_a_addr", v), 32'(a_raddr), 32'd5);
        if (vecs[v].ready[1]) chk($sformatf("vec%0d_a_addr", v), 32'(a_raddr), 32'd9);
      end else begin
        chk($sformatf("vec%0d_b_ready", v), 32'(b_ready), 32'(vecs[v].ready));
        chk($sformatf("vec%0d_b_en", v), 32'(b_en), 32'(|vecs[v].ready));
        if (vecs[v].ready[1]) chk($sformatf("vec%0d_b_addr", v), 32'(b_raddr), 32'd7);
        if (vecs[v].ready[2]) chk($sformatf("vec%0d_b_addr", v), 32'(b_raddr), 32'd15);
      end
      @(posedge clk); #1;
    end
    a_valid = '0; b_valid = '0;
    @(posedge clk); #1;

    // reset with a response in flight
    a_addr[3:0] = 4'd5; a_be[3:0] = 4'h0; a_valid = 2'b01;
    @(posedge clk); #1;
    chk("inflight_rsp", 32'(a_rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp", 32'(a_rsp_valid), 32'd0);
    chk("async_rst_ready", 32'(a_ready), 32'd0);
    chk("async_rst_en", 32'(a_en), 32'd0);
    chk("async_rst_init", 32'(a_init), 32'd0);
    a_valid = '0;
    @(negedge clk); #2 rst_n = 1'b1;
`ifdef BRAM_ARB_CLEAR_EN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("pre_abort_addr", 32'(a_raddr), 32'(i));
    end
    #1 rst_n = 1'b0;
    #1 chk("abort_en", 32'(a_en), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("restart_en", 32'(a_en), 32'd1);
      chk("restart_addr", 32'(a_raddr), 32'(i));
      chk("restart_init", 32'(a_init), 32'd0);
    end
    @(negedge clk);
    chk("restart_done", 32'(a_init), 32'd1);
`else
    @(negedge clk);
    chk("rerst_init", 32'(a_init), 32'd1);
`endif
    @(posedge clk); #1;
    a_do(0, 4'd5, 4'h0, 32'h0);
`ifdef BRAM_ARB_CLEAR_EN
    chk("post_clear_read", a_rsp_data, 32'h0);
`else
    chk("post_reset_read", a_rsp_data, 32'hA1B2EED4);
`endif
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
